// File: rtl/bitvault_pkg.sv
// Shared types and constants for the BitVault 4x8 register file and its read-out engine.
package bitvault_pkg;
    localparam int REG_COUNT = 4;
    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 8;

    localparam logic [7:0] CSUM_SEED = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        SUM
    } rd_state_t;
endpackage

// File: rtl/bitvault_reader.sv
// Walks a wrapping register range through the async read port, streams each byte,
// then appends an XOR checksum byte flagged with m_last.
module bitvault_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    import bitvault_pkg::*;

    rd_state_t         state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W-1:0] rem, rem_n;
    logic [DATA_W-1:0] csum, csum_n;
    logic [DATA_W-1:0] m_data_n;
    logic              m_valid_n, m_last_n, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            rem     <= '0;
            csum    <= DATA_W'(CSUM_SEED);
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            rem     <= rem_n;
            csum    <= csum_n;
            m_data  <= m_data_n;
            m_valid <= m_valid_n;
            m_last  <= m_last_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        rem_n     = rem;
        csum_n    = csum;
        m_data_n  = m_data;
        m_valid_n = m_valid;
        m_last_n  = m_last;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ptr_n   = start_addr;
                    rem_n   = count;
                    csum_n  = DATA_W'(CSUM_SEED);
                    state_n = FETCH;
                end
            end
            FETCH: begin
                m_data_n  = rf_data;
                csum_n    = csum ^ rf_data;
                m_valid_n = 1'b1;
                state_n   = SEND;
            end
            SEND: begin
                if (m_ready) begin
                    if (rem == '0) begin
                        // Last data byte leaves; valid stays high so the checksum follows back-to-back.
                        m_data_n = csum;
                        m_last_n = 1'b1;
                        state_n  = SUM;
                    end else begin
                        ptr_n     = ptr + ADDR_W'(1);
                        rem_n     = rem - ADDR_W'(1);
                        m_valid_n = 1'b0;
                        state_n   = FETCH;
                    end
                end
            end
            SUM: begin
                if (m_ready) begin
                    m_valid_n = 1'b0;
                    m_last_n  = 1'b0;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rf_addr = ptr;
    assign busy    = (state != IDLE);
endmodule
